// File: rtl/varredor_display_aste_if.sv
// Bundles the asteroid-memory read port and the row handshake to the LED-matrix driver.
// master = display scanner, slave = memories plus driver.
interface varredor_display_aste_if #(
  parameter int unsigned W_ADDR = 4,
  parameter int unsigned W_COOR = 4
);
  localparam int unsigned W_DADOS = 2 * W_COOR + 2;
  localparam int unsigned COLS    = 2 ** W_COOR;

  logic [W_ADDR-1:0]  mem_addr;
  logic [W_DADOS-1:0] mem_data;
  logic [1:0]         mem_load;
  logic [W_COOR-1:0]  linha_idx;
  logic [COLS-1:0]    linha_dados;
  logic               linha_valid;
  logic               linha_ready;

  modport master (
    output mem_addr, linha_idx, linha_dados, linha_valid,
    input  mem_data, mem_load, linha_ready
  );

  modport slave (
    input  mem_addr, linha_idx, linha_dados, linha_valid,
    output mem_data, mem_load, linha_ready
  );
endinterface

// File: rtl/varredor_display_aste.sv
// Scans all asteroid slots, rasterises live ones into a frame buffer, then streams rows to the LED driver.
// Optional ship overlay and collision flag when NAVE_OVERLAY_EN is defined.
module varredor_display_aste #(
  parameter int unsigned N_ASTE  = 16,
  parameter int unsigned W_COOR  = 4,
  parameter int unsigned LAT_MEM = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           iniciar,
  input  logic [W_COOR-1:0]              nave_x,
  input  logic [W_COOR-1:0]              nave_y,
  output logic                           ocupado,
  output logic                           pronto,
  output logic [$clog2(N_ASTE+1)-1:0]    n_visiveis,
`ifdef NAVE_OVERLAY_EN
  output logic                           colisao_frame,
`endif
  varredor_display_aste_if.master        bus
);
  localparam int unsigned ROWS   = 2 ** W_COOR;
  localparam int unsigned COLS   = 2 ** W_COOR;
  localparam int unsigned W_ADDR = (N_ASTE > 1) ? $clog2(N_ASTE) : 1;
  localparam int unsigned W_CNT  = $clog2(N_ASTE + 1);
  localparam int unsigned W_LAT  = (LAT_MEM > 1) ? $clog2(LAT_MEM + 1) : 1;

  typedef enum logic [2:0] {OCIOSO, LIMPA, LE, ESPERA, CARREGA, ENVIA, FIM} estado_t;

  estado_t                    state;
  logic [ROWS-1:0][COLS-1:0]  fb;
  logic [W_ADDR-1:0]          slot;
  logic [W_LAT-1:0]           espera;
  logic                       amostra_c;
  logic [W_COOR-1:0]          ast_x_c;
  logic [W_COOR-1:0]          ast_y_c;
  logic                       desenha_c;
  logic                       unused_bits;

`ifdef NAVE_OVERLAY_EN
  logic [W_COOR-1:0]          nave_x_q;
  logic [W_COOR-1:0]          nave_y_q;
  logic                       colide_q;
  assign unused_bits = ^bus.mem_data[1:0];
`else
  assign unused_bits = ^{bus.mem_data[1:0], nave_x, nave_y};
`endif

  // Memory word is valid on the last LE/ESPERA cycle of each slot
  assign amostra_c = ((state == LE) && (LAT_MEM == 0)) ||
                     ((state == ESPERA) && (espera == W_LAT'(LAT_MEM - 1)));
  assign ast_x_c   = bus.mem_data[2*W_COOR+1 -: W_COOR];
  assign ast_y_c   = bus.mem_data[W_COOR+1 -: W_COOR];
  assign desenha_c = bus.mem_load[1] && !bus.mem_load[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= OCIOSO;
      fb              <= '0;
      slot            <= '0;
      espera          <= '0;
      ocupado         <= 1'b0;
      pronto          <= 1'b0;
      n_visiveis      <= '0;
      bus.mem_addr    <= '0;
      bus.linha_idx   <= '0;
      bus.linha_dados <= '0;
      bus.linha_valid <= 1'b0;
`ifdef NAVE_OVERLAY_EN
      nave_x_q        <= '0;
      nave_y_q        <= '0;
      colide_q        <= 1'b0;
      colisao_frame   <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (iniciar) begin
            ocupado <= 1'b1;
            state   <= LIMPA;
`ifdef NAVE_OVERLAY_EN
            nave_x_q <= nave_x;
            nave_y_q <= nave_y;
`endif
          end
        end
        LIMPA: begin
          fb           <= '0;
          n_visiveis   <= '0;
          slot         <= '0;
          bus.mem_addr <= '0;
          state        <= LE;
`ifdef NAVE_OVERLAY_EN
          colisao_frame <= 1'b0;
`endif
        end
        LE, ESPERA: begin
          if (amostra_c) begin
            if (desenha_c) begin
              fb[ast_y_c][ast_x_c] <= 1'b1;
              n_visiveis           <= n_visiveis + W_CNT'(1);
            end
            if (slot == W_ADDR'(N_ASTE - 1)) begin
              state <= CARREGA;
            end else begin
              slot         <= slot + W_ADDR'(1);
              bus.mem_addr <= slot + W_ADDR'(1);
              state        <= LE;
            end
          end else if (state == LE) begin
            espera <= '0;
            state  <= ESPERA;
          end else begin
            espera <= espera + W_LAT'(1);
          end
        end
        // Rasterisation complete: present row 0 (with ship pixel when enabled)
        CARREGA: begin
          bus.linha_idx   <= '0;
          bus.linha_valid <= 1'b1;
          state           <= ENVIA;
`ifdef NAVE_OVERLAY_EN
          fb[nave_y_q][nave_x_q] <= 1'b1;
          colide_q               <= fb[nave_y_q][nave_x_q];
          bus.linha_dados        <= fb[0] | ((nave_y_q == '0) ? (COLS'(1) << nave_x_q) : '0);
`else
          bus.linha_dados        <= fb[0];
`endif
        end
        ENVIA: begin
          if (bus.linha_valid && bus.linha_ready) begin
            if (bus.linha_idx == W_COOR'(ROWS - 1)) begin
              bus.linha_valid <= 1'b0;
              pronto          <= 1'b1;
              state           <= FIM;
`ifdef NAVE_OVERLAY_EN
              colisao_frame   <= colide_q;
`endif
            end else begin
              bus.linha_idx   <= bus.linha_idx + W_COOR'(1);
              bus.linha_dados <= fb[bus.linha_idx + W_COOR'(1)];
            end
          end
        end
        FIM: begin
          ocupado <= 1'b0;
          state   <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end
endmodule
